// File: rtl/fma_pkg.sv
// Shared FP16 constants, types and FSM states for the FMA datapath.
package fma_pkg;

    localparam int         EXP_BIAS = 15;
    localparam int         EXP_MIN  = -14;
    localparam logic [4:0] EXP_INF  = 5'h1F;
    localparam int         MANT_W   = 10;

    typedef struct packed {
        logic              sign;
        logic [4:0]        exp;
        logic [MANT_W-1:0] frac;
    } fp16_t;

    localparam fp16_t FP16_POS_INF = fp16_t'({1'b0, EXP_INF, 10'h000});
    localparam fp16_t FP16_NEG_INF = fp16_t'({1'b1, EXP_INF, 10'h000});

    typedef enum logic [2:0] {
        StIdle,
        StDenorm,
        StNorm,
        StRound,
        StDone
    } state_e;

endpackage

// File: rtl/fp16_rne_rounder.sv
// Combinational round-to-nearest-even and FP16 packing of a normalized
// (or subnormal-aligned) magnitude whose MSB has weight 2^e_i.
module fp16_rne_rounder
    import fma_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned EXP_W = 8
) (
    input  logic [ACC_W-1:0]        m_i,
    input  logic signed [EXP_W+1:0] e_i,
    input  logic                    s_i,
    input  logic                    sticky_i,
    output logic [15:0]             fp16_o,
    output logic                    inexact_o,
    output logic                    overflow_o
);

    localparam int unsigned EW = EXP_W + 2;

    logic [MANT_W:0]        mant_raw;
    logic [MANT_W:0]        mant;
    logic [MANT_W+1:0]      mant_sum;
    logic                   guard;
    logic                   st;
    logic                   round_up;
    logic signed [EW-1:0]   e_adj;
    logic signed [EW-1:0]   biased;
    fp16_t                  res;

    // Round, handle mantissa carry-out, then choose zero/overflow/normal/subnormal packing.
    always_comb begin
        mant_raw = m_i[ACC_W-1 -: MANT_W+1];
        guard    = m_i[ACC_W-MANT_W-2];
        st       = sticky_i | (|m_i[ACC_W-MANT_W-3:0]);
        round_up = guard & (st | mant_raw[0]);
        mant_sum = {1'b0, mant_raw} + {{(MANT_W+1){1'b0}}, round_up};
        e_adj    = e_i;
        mant     = mant_sum[MANT_W:0];
        if (mant_sum[MANT_W+1]) begin
            mant  = {1'b1, {MANT_W{1'b0}}};
            e_adj = e_i + EW'(1);
        end
        biased = e_adj + EW'(EXP_BIAS);

        res        = fp16_t'({s_i, 5'h00, mant[MANT_W-1:0]});
        inexact_o  = guard | st;
        overflow_o = 1'b0;

        if ((m_i == '0) && !sticky_i) begin
            res       = fp16_t'({s_i, 15'h0000});
            inexact_o = 1'b0;
        end else if (mant[MANT_W]) begin
            // A subnormal that rounds up to 0x400 lands here with e == -14, giving field 1.
            if (biased >= EW'(31)) begin
                res        = s_i ? FP16_NEG_INF : FP16_POS_INF;
                overflow_o = 1'b1;
                inexact_o  = 1'b1;
            end else begin
                res.exp = biased[4:0];
            end
        end
        fp16_o = res;
    end

endmodule

// File: rtl/fp16_normalize_pack.sv
// Normalizes a sign/magnitude fixed-point FMA result one bit per cycle,
// rounds to nearest-even and emits a packed FP16 word with valid/ready.
module fp16_normalize_pack
    import fma_pkg::*;
#(
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned FRAC_W = 20,
    parameter int unsigned EXP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [ACC_W-1:0] in_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_fp16,
    output logic             out_inexact,
    output logic             out_overflow
);

    localparam int unsigned EW = EXP_W + 2;
    // Weight of m[MSB] relative to the input exponent.
    localparam logic signed [EW-1:0] EOffset = EW'(int'(ACC_W) - 1 - int'(FRAC_W));
    localparam logic signed [EW-1:0] EMin    = EW'(EXP_MIN);
    // Below this every bit is shifted into sticky anyway; bounds DENORM cycles.
    localparam logic signed [EW-1:0] EClamp  = EW'(EXP_MIN - int'(ACC_W));

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     m_q, m_d;
    logic signed [EW-1:0] e_q, e_d;
    logic                 s_q, s_d;
    logic                 sticky_q, sticky_d;
    logic [15:0]          fp16_q, fp16_d;
    logic                 inexact_q, inexact_d;
    logic                 overflow_q, overflow_d;

    logic signed [EW-1:0] e_in_ext;
    logic signed [EW-1:0] e_cap;
    logic signed [EW-1:0] e_inc;
    logic [15:0]          rnd_fp16;
    logic                 rnd_inexact;
    logic                 rnd_overflow;

    assign e_in_ext = {{2{in_exp[EXP_W-1]}}, in_exp};
    assign e_cap    = e_in_ext + EOffset;
    assign e_inc    = e_q + EW'(1);

    fp16_rne_rounder #(
        .ACC_W (ACC_W),
        .EXP_W (EXP_W)
    ) u_rounder (
        .m_i        (m_q),
        .e_i        (e_q),
        .s_i        (s_q),
        .sticky_i   (sticky_q),
        .fp16_o     (rnd_fp16),
        .inexact_o  (rnd_inexact),
        .overflow_o (rnd_overflow)
    );

    // Next-state and datapath updates for the capture/denorm/norm/round/done sequence.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        e_d        = e_q;
        s_d        = s_q;
        sticky_d   = sticky_q;
        fp16_d     = fp16_q;
        inexact_d  = inexact_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    m_d      = in_mag;
                    s_d      = in_sign;
                    sticky_d = 1'b0;
                    e_d      = (e_cap < EClamp) ? EClamp : e_cap;
                    state_d  = (e_cap < EMin) ? StDenorm : StNorm;
                end
            end
            StDenorm: begin
                sticky_d = sticky_q | m_q[0];
                m_d      = m_q >> 1;
                e_d      = e_inc;
                if (e_inc == EMin) begin
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if ((m_q == '0) || m_q[ACC_W-1] || (e_q == EMin)) begin
                    state_d = StRound;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - EW'(1);
                end
            end
            StRound: begin
                fp16_d     = rnd_fp16;
                inexact_d  = rnd_inexact;
                overflow_d = rnd_overflow;
                state_d    = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            m_q        <= '0;
            e_q        <= '0;
            s_q        <= 1'b0;
            sticky_q   <= 1'b0;
            fp16_q     <= 16'h0000;
            inexact_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            e_q        <= e_d;
            s_q        <= s_d;
            sticky_q   <= sticky_d;
            fp16_q     <= fp16_d;
            inexact_q  <= inexact_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out_fp16     = fp16_q;
    assign out_inexact  = inexact_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Directed table-driven bench for fp16_normalize_pack plus backpressure and reset sequences.
module tb_fp16_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [23:0] in_mag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_fp16;
    logic        out_inexact;
    logic        out_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mag;
        logic [15:0] fp16;
        logic        ix;
        logic        ov;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    fp16_normalize_pack #(
        .ACC_W  (24),
        .FRAC_W (20),
        .EXP_W  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mag       (in_mag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fp16     (out_fp16),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    // Issue one request; return the result and accept-to-valid latency in cycles
    // (the accept edge counts as cycle 1).
    task automatic run_vec(input string name, input logic sg, input logic [7:0] ex,
                           input logic [23:0] mg, output int lat);
        @(negedge clk);
        check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_sign  = sg;
        in_exp   = ex;
        in_mag   = mg;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " in_ready busy"}, 32'(in_ready), 32'd0);
    endtask

    // Accept the pending result and confirm the block returns to idle.
    task automatic release_out(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({name, " valid drop"}, 32'(out_valid), 32'd0);
        check({name, " ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] held;

        vecs[0]  = '{1'b0, 8'h00, 24'h100000, 16'h3C00, 1'b0, 1'b0, 6};
        vecs[1]  = '{1'b1, 8'h00, 24'h100000, 16'hBC00, 1'b0, 1'b0, 6};
        vecs[2]  = '{1'b0, 8'h00, 24'h100200, 16'h3C00, 1'b1, 1'b0, 6};
        vecs[3]  = '{1'b0, 8'h00, 24'h100600, 16'h3C02, 1'b1, 1'b0, 6};
        vecs[4]  = '{1'b0, 8'hE8, 24'h100000, 16'h0001, 1'b0, 1'b0, 10};
        vecs[5]  = '{1'b0, 8'hE6, 24'h100000, 16'h0000, 1'b1, 1'b0, 12};
        vecs[6]  = '{1'b1, 8'h10, 24'h100000, 16'hFC00, 1'b1, 1'b1, 6};
        vecs[7]  = '{1'b0, 8'h0C, 24'hFFFFFF, 16'h7C00, 1'b1, 1'b1, 3};
        vecs[8]  = '{1'b0, 8'h00, 24'h200000, 16'h4000, 1'b0, 1'b0, 5};
        vecs[9]  = '{1'b0, 8'h0F, 24'h1FFC00, 16'h7BFF, 1'b0, 1'b0, 6};
        vecs[10] = '{1'b0, 8'hEF, 24'h7FF000, 16'h0400, 1'b1, 1'b0, 3};
        vecs[11] = '{1'b0, 8'h80, 24'h100000, 16'h0000, 1'b1, 1'b0, 27};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mag    = 24'h0;
        out_ready = 1'b0;
        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_fp16", 32'(out_fp16), 32'h0);
        check("rst inexact", 32'(out_inexact), 32'd0);
        check("rst overflow", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            run_vec(nm, vecs[i].sign, vecs[i].exp, vecs[i].mag, lat);
            check({nm, " fp16"}, 32'(out_fp16), 32'(vecs[i].fp16));
            check({nm, " inexact"}, 32'(out_inexact), 32'(vecs[i].ix));
            check({nm, " overflow"}, 32'(out_overflow), 32'(vecs[i].ov));
            check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            release_out(nm);
        end

        // Negative zero with consumer backpressure.
        run_vec("zero", 1'b1, 8'h00, 24'h000000, lat);
        check("zero latency", 32'(lat), 32'd3);
        held = out_fp16;
        check("zero fp16", 32'(held), 32'h8000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d fp16", c), 32'(out_fp16), 32'h8000);
            check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
        end
        release_out("bp");

        // Asynchronous reset in the middle of normalization.
        @(negedge clk);
        in_sign  = 1'b0;
        in_exp   = 8'hF0;
        in_mag   = 24'h100000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid in_ready busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst out_fp16", 32'(out_fp16), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("post", 1'b0, 8'h00, 24'h100000, lat);
        check("post fp16", 32'(out_fp16), 32'h3C00);
        check("post inexact", 32'(out_inexact), 32'd0);
        release_out("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
